mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported memory between instruction fetch (I) and load/store (D) requesters.
//   D has priority; an anti-starvation counter forces an I grant after MAX_D_STREAK D grants
//   while I is waiting. At most one transaction is in flight; the response goes back to its owner.
//   Sits between the fetch stage / LSU (byte enables from the controller's dmem_wr_en) and memory.
// PARAMETERS
//   ADDR_W        32  address width
//   DATA_W        32  data width; must be 32 (4 byte lanes)
//   MAX_D_STREAK  4   consecutive D grants allowed while i_req is pending (range 1..15)
// PORTS
//   clk       in   1       clock; all state updates on the rising edge
//   rst       in   1       synchronous reset, active-high
//   i_req     in   1       fetch request; held with i_addr until i_gnt
//   i_addr    in   ADDR_W  fetch address
//   i_gnt     out  1       fetch request accepted by memory
//   i_rvalid  out  1       fetch data valid, 1-cycle pulse
//   i_rdata   out  DATA_W  fetch data
//   d_req     in   1       data request; held with d_addr/d_wdata/d_wr_en until d_gnt
//   d_addr    in   ADDR_W  data address
//   d_wdata   in   DATA_W  store data
//   d_wr_en   in   4       byte write enables; 4'b0000 = load
//   d_gnt     out  1       data request accepted by memory
//   d_rvalid  out  1       load data / store ack, 1-cycle pulse
//   d_rdata   out  DATA_W  load data
//   m_req     out  1       memory request
//   m_addr    out  ADDR_W  memory address
//   m_wdata   out  DATA_W  memory write data
//   m_wr_en   out  4       memory byte enables (0 for fetch and load)
//   m_gnt     in   1       memory accepts m_req in this cycle
//   m_rvalid  in   1       memory response (read data or write ack)
//   m_rdata   in   DATA_W  memory read data
//   busy      out  1       state != IDLE
// BEHAVIOUR
//   - FSM arb_state_t {IDLE, REQ, WAIT}; owner register arb_owner_t {OWN_I, OWN_D}.
//   - IDLE: if d_req|i_req, latch the winner into owner and go to REQ. Winner rules:
//     D if d_req and not (i_req and streak==MAX_D_STREAK); otherwise I. Stay in IDLE if no request.
//   - REQ: m_req=1; m_addr/m_wdata/m_wr_en are muxed from the owner (I: wr_en=0, wdata=0).
//     On m_gnt: pulse i_gnt or d_gnt (owner, combinational, same cycle), then go to WAIT.
//   - WAIT: m_req=0. On m_rvalid: pulse the owner's rvalid in the same cycle, then go to IDLE.
//   - i_rdata = d_rdata = m_rdata (pass-through). Rvalid is gated by owner and state.
//   - Minimum latency req->rvalid is 3 cycles (IDLE, REQ+gnt, WAIT+rvalid).
//   - Next arbitration happens in the cycle after rvalid; the arbiter never accepts back-to-back
//     in the same cycle.
//   - Streak counter (4b):
//     - +1 on a D grant while i_req=1; saturates at MAX_D_STREAK.
//     - Cleared on an I grant, or when i_req=0 in IDLE.
//   - m_gnt outside REQ and m_rvalid outside WAIT are ignored. No outputs are driven by them.
//   - Owner and request fields are frozen from IDLE->REQ until gnt. Lowering the requester's
//     req during REQ is illegal; the bench flags it with an assertion.
//   - Simultaneous i_req and d_req in IDLE resolve by the winner rule. The loser waits, is not
//     granted, and sees no response pulse.
//   - Reset (any state, including mid-transaction): state=IDLE, owner=OWN_I, streak=0.
//     Outputs: m_req=0, m_addr=0, m_wdata=0, m_wr_en=0, i_gnt=d_gnt=0, i_rvalid=d_rvalid=0, busy=0.
//     An in-flight response arriving after reset is dropped.
// STRUCTURE
//   - Add to lib_pkg: arb_state_t, arb_owner_t, and localparam BYTE_LANES=4.
//   - One sub-module, arb_streak_ctr (saturating counter, MAX parameter, inc/clr/at_max).
//   - FSM, owner register and muxes stay in this module.
// TESTING
//   1. Reset, then i_req=1, i_addr=0x100, m_gnt=1 in REQ, m_rvalid one cycle later with
//      m_rdata=0xDEADBEEF -> i_gnt one pulse, then i_rvalid=1 with i_rdata=0xDEADBEEF;
//      cycles 1/2/3 after req; m_wr_en=0.
//   2. i_req and d_req asserted together in the same cycle, d_wr_en=4'b0011, d_addr=0x200,
//      d_wdata=0x1234 -> D served first: m_wr_en=0011, m_wdata=0x1234. I is served next.
//   3. d_req held high for 10 transactions, i_req high -> grants D,D,D,D,I,D,D,D,D,I.
//   4. m_gnt held low 5 cycles in REQ with d_req -> m_req stays 1, m_addr stable, d_gnt=0
//      until m_gnt=1.
//   5. Spurious m_rvalid in IDLE and m_gnt in WAIT -> no i/d_gnt or i/d_rvalid pulses,
//      state unchanged.
//   6. rst=1 in WAIT, then m_rvalid arrives after reset -> all outputs 0, rvalid not forwarded,
//      next request arbitrates normally.

Source files
------------

// File: rtl/lib_pkg.sv
// -----------------------------------------------------------------------------
// lib_pkg
//   Shared types and constants for the memory port arbiter.
//   - BYTE_LANES : number of byte lanes on the 32-bit data path
//   - STREAK_W   : width of the D-streak counter
//   - arb_state_t: arbiter FSM states
//   - arb_owner_t: which requester owns the current transaction
//   - arb_pick() : winner rule applied in IDLE
// -----------------------------------------------------------------------------
package lib_pkg;

    localparam int BYTE_LANES = 4;
    localparam int STREAK_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // D wins unless fetch is waiting and D has already used up its streak.
    function automatic arb_owner_t arb_pick(input logic req_i,
                                            input logic req_d,
                                            input logic streak_full);
        if (req_d && !(req_i && streak_full)) begin
            return OWN_D;
        end
        return OWN_I;
    endfunction

endpackage

// File: rtl/arb_streak_ctr.sv
// -----------------------------------------------------------------------------
// arb_streak_ctr
//   Saturating up-counter tracking consecutive D grants made while fetch waits.
//   Clear has priority over increment; the count never exceeds MAX.
// Ports
//   clk       in  clock
//   rst       in  synchronous reset, active-high
//   i_inc     in  count one D grant
//   i_clr     in  restart the streak
//   o_at_max  out count has reached MAX
// -----------------------------------------------------------------------------
module arb_streak_ctr #(
    parameter int MAX = 4,
    parameter int W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_C)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (I) and
//   load/store (D). D has priority, but after MAX_D_STREAK D grants made while
//   fetch is waiting, the next arbitration goes to fetch. One transaction is in
//   flight at a time and its response is steered back to the owner.
//
// Parameters
//   ADDR_W        address width
//   DATA_W        data width, 32 (four byte lanes)
//   MAX_D_STREAK  D grants allowed back-to-back while fetch waits (1..15)
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt             fetch request and its acceptance pulse
//   i_rvalid/i_rdata                  fetch response
//   d_req/d_addr/d_wdata/d_wr_en      load/store request (wr_en 0 = load)
//   d_gnt, d_rvalid/d_rdata           load/store acceptance and response
//   m_req/m_addr/m_wdata/m_wr_en      request towards memory
//   m_gnt, m_rvalid/m_rdata           memory acceptance and response
//   busy                              a transaction is in progress
//
// States
//   IDLE | no transaction; arbitrate between pending requests
//   REQ  | m_req raised for the owner, waiting for m_gnt
//   WAIT | request accepted, waiting for m_rvalid
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import lib_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,

    input  logic                  d_req,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [BYTE_LANES-1:0] d_wr_en,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  m_req,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [BYTE_LANES-1:0] m_wr_en,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,

    output logic                  busy
);

    arb_state_t            r_state;
    arb_owner_t            r_owner;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [BYTE_LANES-1:0] r_wr_en;

    logic       w_gnt_fire;
    logic       w_rsp_fire;
    logic       w_at_max;
    logic       w_streak_inc;
    logic       w_streak_clr;
    arb_owner_t w_win;

    // m_gnt and m_rvalid only mean something in their own state.
    assign w_gnt_fire = (r_state == REQ)  && m_gnt;
    assign w_rsp_fire = (r_state == WAIT) && m_rvalid;

    assign w_win = arb_pick(i_req, d_req, w_at_max);

    // The streak only grows while fetch is actually waiting; a fetch grant or
    // an idle cycle with no fetch pending starts it over.
    assign w_streak_inc = w_gnt_fire && (r_owner == OWN_D) && i_req;
    assign w_streak_clr = (w_gnt_fire && (r_owner == OWN_I)) ||
                          ((r_state == IDLE) && !i_req);

    arb_streak_ctr #(
        .MAX (MAX_D_STREAK),
        .W   (STREAK_W)
    ) u_streak (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_streak_inc),
        .i_clr    (w_streak_clr),
        .o_at_max (w_at_max)
    );

    // Request fields are captured from the winner on IDLE->REQ. Requesters
    // hold them until granted, so this equals muxing from the owner, and it
    // keeps m_addr/m_wdata/m_wr_en registered and zero outside REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OWN_I;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr_en <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req || d_req) begin
                        r_state <= REQ;
                        r_owner <= w_win;
                        if (w_win == OWN_D) begin
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                            r_wr_en <= d_wr_en;
                        end else begin
                            r_addr  <= i_addr;
                            r_wdata <= '0;
                            r_wr_en <= '0;
                        end
                    end
                end
                REQ: begin
                    if (m_gnt) begin
                        r_state <= WAIT;
                        r_addr  <= '0;
                        r_wdata <= '0;
                        r_wr_en <= '0;
                    end
                end
                WAIT: begin
                    if (m_rvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_req   = (r_state == REQ);
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign m_wr_en = r_wr_en;

    assign i_gnt    = w_gnt_fire && (r_owner == OWN_I);
    assign d_gnt    = w_gnt_fire && (r_owner == OWN_D);
    assign i_rvalid = w_rsp_fire && (r_owner == OWN_I);
    assign d_rvalid = w_rsp_fire && (r_owner == OWN_D);

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference (in flight / granted flags plus a D-streak count) predicts every
//   cycle's outputs from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wr_en;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_req;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wr_en;
    logic          m_gnt;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_D_STREAK (MAXS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wr_en  (d_wr_en),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wr_en  (m_wr_en),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .busy     (busy)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    bit       chk_en    = 1'b0;
    bit       md_busy   = 1'b0;   // a transaction has been arbitrated, not yet answered
    bit       md_gnted  = 1'b0;   // memory has accepted it
    bit       md_own_d  = 1'b0;   // it belongs to D
    int       md_streak = 0;      // D grants since fetch last got in, while fetch waited
    bit       ev_i      = 1'b0;   // model saw an I grant (stimulus uses it to drop req)
    bit       ev_d      = 1'b0;
    int       gnt_cnt   = 0;
    logic [9:0] gnt_bits = '0;    // grant order, 1 = D
    int       n_ig      = 0;
    int       n_dg      = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic e_req, e_ig, e_dg, e_irv, e_drv;
                e_req = md_busy && !md_gnted;
                e_ig  = e_req && !md_own_d && m_gnt;
                e_dg  = e_req &&  md_own_d && m_gnt;
                e_irv = md_busy && md_gnted && !md_own_d && m_rvalid;
                e_drv = md_busy && md_gnted &&  md_own_d && m_rvalid;

                assert (!e_req || (md_own_d ? d_req : i_req))
                    else $error("FAIL req_drop: requester lowered req before grant");

                chk("busy",     busy,     md_busy);
                chk("m_req",    m_req,    e_req);
                chk("i_gnt",    i_gnt,    e_ig);
                chk("d_gnt",    d_gnt,    e_dg);
                chk("i_rvalid", i_rvalid, e_irv);
                chk("d_rvalid", d_rvalid, e_drv);
                chk("i_rdata",  i_rdata,  m_rdata);
                chk("d_rdata",  d_rdata,  m_rdata);
                if (e_req) begin
                    chk("m_addr",  m_addr,  md_own_d ? d_addr  : i_addr);
                    chk("m_wdata", m_wdata, md_own_d ? d_wdata : 32'h0);
                    chk("m_wr_en", m_wr_en, md_own_d ? d_wr_en : 4'h0);
                end

                if (rst) begin
                    md_busy   = 1'b0;
                    md_gnted  = 1'b0;
                    md_own_d  = 1'b0;
                    md_streak = 0;
                end else if (!md_busy) begin
                    if (!i_req) md_streak = 0;
                    if (i_req || d_req) begin
                        md_busy  = 1'b1;
                        md_gnted = 1'b0;
                        md_own_d = d_req && !(i_req && md_streak >= MAXS);
                    end
                end else if (!md_gnted) begin
                    if (m_gnt) begin
                        md_gnted = 1'b1;
                        gnt_cnt++;
                        gnt_bits = {gnt_bits[8:0], md_own_d};
                        if (md_own_d) begin
                            ev_d = 1'b1;
                            n_dg++;
                            if (i_req && md_streak < MAXS) md_streak++;
                        end else begin
                            ev_i = 1'b1;
                            n_ig++;
                            md_streak = 0;
                        end
                    end
                end else if (m_rvalid) begin
                    md_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_wdata = 0; d_wr_en = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",    busy,    0);
        chk("rst_m_req",   m_req,   0);
        chk("rst_m_addr",  m_addr,  0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_wr_en", m_wr_en, 0);
        tick();

        // 1: single fetch, minimum latency
        i_req = 1; i_addr = 32'h100; m_gnt = 1;
        @(negedge clk);
        chk("t1_c1_gnt", i_gnt, 0);
        tick();
        @(negedge clk);
        chk("t1_c2_gnt",  i_gnt,   1);
        chk("t1_c2_addr", m_addr,  32'h100);
        chk("t1_c2_we",   m_wr_en, 0);
        tick();
        i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_c3_rv",    i_rvalid, 1);
        chk("t1_c3_rdata", i_rdata,  32'hDEADBEEF);
        chk("t1_c3_gnt",   i_gnt,    0);
        tick();
        m_rvalid = 0;
        @(negedge clk);
        chk("t1_c4_busy", busy, 0);
        tick();

        // 2: simultaneous requests, D first then I
        i_req = 1; i_addr = 32'h300;
        d_req = 1; d_addr = 32'h200; d_wdata = 32'h1234; d_wr_en = 4'b0011; m_gnt = 1;
        tick();
        @(negedge clk);
        chk("t2_dgnt",  d_gnt,   1);
        chk("t2_ignt",  i_gnt,   0);
        chk("t2_we",    m_wr_en, 4'b0011);
        chk("t2_wdata", m_wdata, 32'h1234);
        chk("t2_addr",  m_addr,  32'h200);
        tick();
        d_req = 0; m_rvalid = 1; m_rdata = 32'h0BAD0001;
        @(negedge clk);
        chk("t2_drv", d_rvalid, 1);
        chk("t2_irv", i_rvalid, 0);
        tick();
        m_rvalid = 0;
        tick();
        @(negedge clk);
        chk("t2_i_gnt",  i_gnt,   1);
        chk("t2_i_addr", m_addr,  32'h300);
        chk("t2_i_we",   m_wr_en, 0);
        tick();
        i_req = 0; m_rvalid = 1;
        @(negedge clk);
        chk("t2_i_rv", i_rvalid, 1);
        tick();
        m_rvalid = 0; m_gnt = 0; d_wr_en = 0;
        tick();

        // 3: both held high, anti-starvation pattern
        gnt_cnt = 0;
        i_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1;
        for (int k = 0; k < 200; k++) begin
            if (gnt_cnt >= 10) break;
            tick();
        end
        i_req = 0; d_req = 0;
        chk("t3_ngrants", gnt_cnt, 10);
        chk("t3_order", gnt_bits, 10'b1111011110);
        tick();
        m_gnt = 0; m_rvalid = 0;
        tick();

        // 4: memory stalls in REQ
        d_req = 1; d_addr = 32'h440; d_wdata = 32'h55; d_wr_en = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_mreq",  m_req,  1);
            chk("t4_maddr", m_addr, 32'h440);
            chk("t4_dgnt",  d_gnt,  0);
            tick();
        end
        m_gnt = 1;
        @(negedge clk);
        chk("t4_dgnt_final", d_gnt, 1);
        tick();
        d_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hCAFE0001;
        @(negedge clk);
        chk("t4_drv", d_rvalid, 1);
        tick();
        m_rvalid = 0; d_wr_en = 0;
        tick();

        // 5: spurious memory handshakes
        m_rvalid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_idle_busy", busy, 0);
            chk("t5_idle_irv",  i_rvalid, 0);
            chk("t5_idle_drv",  d_rvalid, 0);
            tick();
        end
        m_rvalid = 0; i_req = 1; i_addr = 32'h500; m_gnt = 1;
        tick();
        tick();
        i_req = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_wait_busy", busy,  1);
            chk("t5_wait_ignt", i_gnt, 0);
            chk("t5_wait_dgnt", d_gnt, 0);
            tick();
        end
        m_gnt = 0; m_rvalid = 1;
        @(negedge clk);
        chk("t5_irv", i_rvalid, 1);
        tick();
        m_rvalid = 0;
        tick();

        // 6: reset during WAIT drops the late response
        d_req = 1; d_addr = 32'h680; d_wr_en = 4'b0000; m_gnt = 1;
        tick();
        tick();
        d_req = 0; m_gnt = 0; rst = 1;
        @(negedge clk);
        chk("t6_pre_busy", busy, 1);
        tick();
        rst = 0; m_rvalid = 1; m_rdata = 32'h66;
        @(negedge clk);
        chk("t6_drv",   d_rvalid, 0);
        chk("t6_irv",   i_rvalid, 0);
        chk("t6_busy",  busy,     0);
        chk("t6_mreq",  m_req,    0);
        chk("t6_maddr", m_addr,   0);
        tick();
        m_rvalid = 0; i_req = 1; i_addr = 32'h600; m_gnt = 1;
        tick();
        @(negedge clk);
        chk("t6_ignt",  i_gnt,  1);
        chk("t6_iaddr", m_addr, 32'h600);
        tick();
        i_req = 0; m_gnt = 0; m_rvalid = 1;
        @(negedge clk);
        chk("t6_irv_after", i_rvalid, 1);
        tick();
        m_rvalid = 0;
        tick();

        // random traffic
        ev_i = 0; ev_d = 0; n_ig = 0; n_dg = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (ev_i) begin ev_i = 0; i_req = 0; end
            if (ev_d) begin ev_d = 0; d_req = 0; end
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1;
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_wr_en = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            end
            m_gnt    = ($urandom_range(0, 2) != 0);
            m_rvalid = ($urandom_range(0, 1) == 1);
            m_rdata  = $urandom;
            tick();
        end
        chk("rand_i_grants", (n_ig > 0), 1);
        chk("rand_d_grants", (n_dg > 0), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
